// File: rtl/rob_multi_commit.sv
// rob_multi_commit
//   Reorder buffer with in-order retirement of up to COMMIT_W entries per cycle.
//   Entries are allocated at the tail by the decoder, completed out of order by
//   WB_PORTS writeback ports, and retired from the head. Control ops (jalr,
//   branches, exit) retire alone in slot 0. A mispredicted branch empties the
//   buffer on the retiring edge and raises flush plus a pc redirect.
//
// Ports
//   clk_in, rst_in (async, active-low), rdy_in (0 = freeze state, pulses 0)
//   issue_*        : allocation request; issue_ready / issue_id back to decoder
//   q1_* / q2_*    : operand lookups with same-cycle writeback bypass
//   wb_*           : packed per-port writeback strobes, ids, values, jalr targets
//   cm_*           : registered per-slot retirement to the regfile
//   redirect_*     : pc redirect pulse (jalr or mispredict)
//   bp_*           : predictor update pulse on branch retirement
//   flush          : one-cycle pulse after a mispredict retires
//   head_id, count : oldest entry and occupancy; halt : sticky after exit retires

module rob_multi_commit #(
   parameter int DEPTH    = 16,
   parameter int IDX_W    = $clog2(DEPTH),
   parameter int REG_W    = 5,
   parameter int WB_PORTS = 3,
   parameter int COMMIT_W = 2
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic                      rdy_in,
   input  logic                      issue_valid,
   input  logic [5:0]                issue_op,
   input  logic [REG_W-1:0]          issue_rd,
   input  logic [31:0]               issue_pc,
   input  logic [31:0]               issue_imm,
   input  logic                      issue_pred,
   output logic                      issue_ready,
   output logic [IDX_W-1:0]          issue_id,
   input  logic [IDX_W-1:0]          q1_id,
   input  logic [IDX_W-1:0]          q2_id,
   output logic                      q1_ready,
   output logic                      q2_ready,
   output logic [31:0]               q1_value,
   output logic [31:0]               q2_value,
   input  logic [WB_PORTS-1:0]       wb_valid,
   input  logic [WB_PORTS*IDX_W-1:0] wb_id,
   input  logic [WB_PORTS*32-1:0]    wb_value,
   input  logic [WB_PORTS*32-1:0]    wb_target,
   output logic [COMMIT_W-1:0]       cm_valid,
   output logic [COMMIT_W*REG_W-1:0] cm_rd,
   output logic [COMMIT_W*IDX_W-1:0] cm_id,
   output logic [COMMIT_W*32-1:0]    cm_value,
   output logic                      redirect_valid,
   output logic [31:0]               redirect_pc,
   output logic                      bp_valid,
   output logic [31:0]               bp_pc,
   output logic                      bp_taken,
   output logic                      bp_pred,
   output logic                      flush,
   output logic [IDX_W-1:0]          head_id,
   output logic [IDX_W:0]            count,
   output logic                      halt
);

   localparam logic [5:0] OP_JALR = 6'd3;
   localparam logic [5:0] OP_EXIT = 6'd39;

   function automatic logic is_branch(input logic [5:0] op);
      return (op >= 6'd4) && (op <= 6'd9);
   endfunction

   function automatic logic is_ctrl(input logic [5:0] op);
      return (op == OP_JALR) || is_branch(op) || (op == OP_EXIT);
   endfunction

   // entry state
   logic [DEPTH-1:0]  valid_q;
   logic [DEPTH-1:0]  done_q;
   logic [5:0]        op_q     [DEPTH];
   logic [REG_W-1:0]  rd_q     [DEPTH];
   logic [31:0]       pc_q     [DEPTH];
   logic [31:0]       imm_q    [DEPTH];
   logic              pred_q   [DEPTH];
   logic [31:0]       value_q  [DEPTH];
   logic [31:0]       target_q [DEPTH];

   logic [IDX_W-1:0]  head_q;
   logic [IDX_W-1:0]  tail_q;

   // unpacked writeback ports
   logic [IDX_W-1:0]  wb_id_a  [WB_PORTS];
   logic [31:0]       wb_val_a [WB_PORTS];
   logic [31:0]       wb_tgt_a [WB_PORTS];
   logic [WB_PORTS-1:0] wb_ok;

   // retirement decode
   logic [IDX_W-1:0]  slot_idx [COMMIT_W];
   logic [COMMIT_W-1:0] ret_slot;
   logic [IDX_W:0]    n_ret;
   logic              stop;
   logic              issue_fire;
   logic              head_jalr;
   logic              head_branch;
   logic              head_exit;
   logic              mispredict;
   logic [31:0]       fix_pc;

   assign head_id     = head_q;
   assign issue_id    = tail_q;
   // Registered count, so a full buffer refuses issue even while it retires.
   assign issue_ready = (count < (IDX_W+1)'(DEPTH)) && !flush;
   assign issue_fire  = rdy_in && issue_valid && issue_ready;

   always_comb begin
      for (int p = 0; p < WB_PORTS; p++) begin
         wb_id_a[p]  = wb_id[p*IDX_W +: IDX_W];
         wb_val_a[p] = wb_value[p*32 +: 32];
         wb_tgt_a[p] = wb_target[p*32 +: 32];
         // Writebacks landing in the flush-pulse cycle belong to squashed work.
         wb_ok[p]    = wb_valid[p] && valid_q[wb_id_a[p]] && !flush;
      end
   end

   // Operand lookups: stored result, or a writeback arriving this cycle.
   always_comb begin
      q1_ready = valid_q[q1_id] && done_q[q1_id];
      q1_value = value_q[q1_id];
      q2_ready = valid_q[q2_id] && done_q[q2_id];
      q2_value = value_q[q2_id];
      for (int p = 0; p < WB_PORTS; p++) begin
         if (wb_valid[p] && (wb_id_a[p] == q1_id)) begin
            q1_ready = 1'b1;
            q1_value = wb_val_a[p];
         end
         if (wb_valid[p] && (wb_id_a[p] == q2_id)) begin
            q2_ready = 1'b1;
            q2_value = wb_val_a[p];
         end
      end
      if (!q1_ready) q1_value = '0;
      if (!q2_ready) q2_value = '0;
   end

   // Slot k retires only if every older slot retires and none of them is a
   // control op; a control op itself may only occupy slot 0.
   always_comb begin
      ret_slot = '0;
      n_ret    = '0;
      stop     = halt || !rdy_in || flush;
      for (int k = 0; k < COMMIT_W; k++) begin
         slot_idx[k] = head_q + IDX_W'(k);
      end
      for (int k = 0; k < COMMIT_W; k++) begin
         if (!stop && valid_q[slot_idx[k]] && done_q[slot_idx[k]] &&
             ((k == 0) || !is_ctrl(op_q[slot_idx[k]]))) begin
            ret_slot[k] = 1'b1;
            n_ret       = n_ret + 1'b1;
            if (is_ctrl(op_q[slot_idx[k]])) stop = 1'b1;
         end else begin
            stop = 1'b1;
         end
      end
   end

   assign head_jalr   = ret_slot[0] && (op_q[head_q] == OP_JALR);
   assign head_branch = ret_slot[0] && is_branch(op_q[head_q]);
   assign head_exit   = ret_slot[0] && (op_q[head_q] == OP_EXIT);
   assign mispredict  = head_branch && (value_q[head_q][0] != pred_q[head_q]);
   assign fix_pc      = pc_q[head_q] + (value_q[head_q][0] ? imm_q[head_q] : 32'd4);

   // Control state and registered outputs.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         valid_q        <= '0;
         done_q         <= '0;
         head_q         <= '0;
         tail_q         <= '0;
         count          <= '0;
         halt           <= 1'b0;
         cm_valid       <= '0;
         cm_rd          <= '0;
         cm_id          <= '0;
         cm_value       <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         bp_valid       <= 1'b0;
         bp_pc          <= '0;
         bp_taken       <= 1'b0;
         bp_pred        <= 1'b0;
         flush          <= 1'b0;
      end else if (!rdy_in) begin
         cm_valid       <= '0;
         redirect_valid <= 1'b0;
         bp_valid       <= 1'b0;
         flush          <= 1'b0;
      end else begin
         cm_valid       <= ret_slot;
         redirect_valid <= 1'b0;
         bp_valid       <= 1'b0;
         flush          <= 1'b0;

         for (int k = 0; k < COMMIT_W; k++) begin
            if (ret_slot[k]) begin
               cm_rd[k*REG_W +: REG_W] <= rd_q[slot_idx[k]];
               cm_id[k*IDX_W +: IDX_W] <= slot_idx[k];
               cm_value[k*32 +: 32]    <= value_q[slot_idx[k]];
            end
         end

         if (head_jalr) begin
            redirect_valid <= 1'b1;
            redirect_pc    <= target_q[head_q];
         end
         if (head_branch) begin
            bp_valid <= 1'b1;
            bp_pc    <= pc_q[head_q];
            bp_taken <= value_q[head_q][0];
            bp_pred  <= pred_q[head_q];
         end
         if (head_exit) halt <= 1'b1;

         for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_ok[p]) done_q[wb_id_a[p]] <= 1'b1;
         end
         for (int k = 0; k < COMMIT_W; k++) begin
            if (ret_slot[k]) valid_q[slot_idx[k]] <= 1'b0;
         end
         if (issue_fire) begin
            valid_q[tail_q] <= 1'b1;
            done_q[tail_q]  <= 1'b0;
         end

         if (mispredict) begin
            // Squash everything, including any issue accepted this cycle.
            valid_q        <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count          <= '0;
            flush          <= 1'b1;
            redirect_valid <= 1'b1;
            redirect_pc    <= fix_pc;
         end else begin
            head_q <= head_q + n_ret[IDX_W-1:0];
            tail_q <= tail_q + IDX_W'(issue_fire);
            count  <= count + (IDX_W+1)'(issue_fire) - n_ret;
         end
      end
   end

   // Entry payload; meaningful only while the matching valid bit is set.
   always_ff @(posedge clk_in) begin
      if (rdy_in) begin
         for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_ok[p]) begin
               value_q[wb_id_a[p]]  <= wb_val_a[p];
               target_q[wb_id_a[p]] <= wb_tgt_a[p];
            end
         end
         if (issue_fire) begin
            op_q[tail_q]   <= issue_op;
            rd_q[tail_q]   <= issue_rd;
            pc_q[tail_q]   <= issue_pc;
            imm_q[tail_q]  <= issue_imm;
            pred_q[tail_q] <= issue_pred;
         end
      end
   end

endmodule

// File: tb/tb_rob_multi_commit.sv
module tb_rob_multi_commit;
   localparam int DEPTH    = 16;
   localparam int IDX_W    = 4;
   localparam int REG_W    = 5;
   localparam int WB_PORTS = 3;
   localparam int COMMIT_W = 2;

   logic clk_in = 1'b0;
   logic rst_in = 1'b0;
   logic rdy_in = 1'b1;
   logic issue_valid = 1'b0;
   logic [5:0] issue_op = '0;
   logic [REG_W-1:0] issue_rd = '0;
   logic [31:0] issue_pc = '0, issue_imm = '0;
   logic issue_pred = 1'b0;
   logic issue_ready;
   logic [IDX_W-1:0] issue_id;
   logic [IDX_W-1:0] q1_id = '0, q2_id = '0;
   logic q1_ready, q2_ready;
   logic [31:0] q1_value, q2_value;
   logic [WB_PORTS-1:0] wb_valid = '0;
   logic [WB_PORTS*IDX_W-1:0] wb_id = '0;
   logic [WB_PORTS*32-1:0] wb_value = '0, wb_target = '0;
   logic [COMMIT_W-1:0] cm_valid;
   logic [COMMIT_W*REG_W-1:0] cm_rd;
   logic [COMMIT_W*IDX_W-1:0] cm_id;
   logic [COMMIT_W*32-1:0] cm_value;
   logic redirect_valid, bp_valid, bp_taken, bp_pred, flush, halt;
   logic [31:0] redirect_pc, bp_pc;
   logic [IDX_W-1:0] head_id;
   logic [IDX_W:0] count;

   int errors = 0;
   int checks = 0;
   int exp_q[$];
   logic [REG_W-1:0] model_rd [DEPTH];
   logic [31:0] model_val [DEPTH];
   int m_tail = 0;
   int mon_id;

   rob_multi_commit #(.DEPTH(DEPTH), .IDX_W(IDX_W), .REG_W(REG_W),
                      .WB_PORTS(WB_PORTS), .COMMIT_W(COMMIT_W)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .issue_valid(issue_valid), .issue_op(issue_op), .issue_rd(issue_rd),
      .issue_pc(issue_pc), .issue_imm(issue_imm), .issue_pred(issue_pred),
      .issue_ready(issue_ready), .issue_id(issue_id),
      .q1_id(q1_id), .q2_id(q2_id), .q1_ready(q1_ready), .q2_ready(q2_ready),
      .q1_value(q1_value), .q2_value(q2_value),
      .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value), .wb_target(wb_target),
      .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_id(cm_id), .cm_value(cm_value),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .bp_valid(bp_valid), .bp_pc(bp_pc), .bp_taken(bp_taken), .bp_pred(bp_pred),
      .flush(flush), .head_id(head_id), .count(count), .halt(halt)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #400000;
      $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   // Scoreboard: every retirement must match the oldest outstanding issue.
   always @(negedge clk_in) begin
      if (rst_in) begin
         for (int k = 0; k < COMMIT_W; k++) begin
            if (cm_valid[k]) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL commit_unexpected slot=%0d got id=%0d want none", k, cm_id[k*IDX_W +: IDX_W]);
               end else begin
                  mon_id = exp_q.pop_front();
                  if (cm_id[k*IDX_W +: IDX_W] !== IDX_W'(mon_id) ||
                      cm_rd[k*REG_W +: REG_W] !== model_rd[mon_id] ||
                      cm_value[k*32 +: 32] !== model_val[mon_id]) begin
                     errors++;
                     $display("FAIL commit_slot%0d got id=%0d rd=%0d val=%0h want id=%0d rd=%0d val=%0h", k,
                              cm_id[k*IDX_W +: IDX_W], cm_rd[k*REG_W +: REG_W], cm_value[k*32 +: 32],
                              mon_id, model_rd[mon_id], model_val[mon_id]);
                  end
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic apply_reset();
      rst_in = 1'b0;
      rdy_in = 1'b1;
      issue_valid = 1'b0;
      wb_valid = '0;
      #2;
      exp_q.delete();
      m_tail = 0;
      tick();
      rst_in = 1'b1;
   endtask

   task automatic do_issue(input logic [5:0] op, input logic [REG_W-1:0] rd,
                           input logic [31:0] pc, input logic [31:0] imm, input logic pred);
      issue_op = op; issue_rd = rd; issue_pc = pc; issue_imm = imm; issue_pred = pred;
      issue_valid = 1'b1;
      exp_q.push_back(m_tail);
      model_rd[m_tail] = rd;
      m_tail = (m_tail + 1) % DEPTH;
      tick();
      issue_valid = 1'b0;
   endtask

   task automatic drive_wb(input logic [2:0] v, input int i0, input int i1, input int i2,
                           input logic [31:0] x0, input logic [31:0] x1, input logic [31:0] x2,
                           input logic [31:0] t0);
      wb_valid  = v;
      wb_id     = {IDX_W'(i2), IDX_W'(i1), IDX_W'(i0)};
      wb_value  = {x2, x1, x0};
      wb_target = {32'd0, 32'd0, t0};
      if (v[0]) model_val[i0] = x0;
      if (v[1]) model_val[i1] = x1;
      if (v[2]) model_val[i2] = x2;
   endtask

   task automatic test_reset();
      rst_in = 1'b0;
      #3;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready got=%0b want=1", issue_ready); end
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", count); end
      checks++; if (head_id !== 4'd0 || issue_id !== 4'd0) begin errors++; $display("FAIL reset_ptrs got head=%0d tail=%0d want 0 0", head_id, issue_id); end
      checks++; if ({cm_valid, flush, redirect_valid, bp_valid, halt} !== 6'd0) begin errors++; $display("FAIL reset_pulses got=%0b want=0", {cm_valid, flush, redirect_valid, bp_valid, halt}); end
      checks++; if (redirect_pc !== 32'd0 || cm_value !== '0) begin errors++; $display("FAIL reset_regs got pc=%0h val=%0h want 0", redirect_pc, cm_value); end
      apply_reset();
   endtask

   task automatic test_multi_commit();
      apply_reset();
      for (int i = 0; i < 4; i++) do_issue(6'd0, REG_W'(i + 1), 32'(i * 4), 32'd0, 1'b0);
      drive_wb(3'b001, 1, 0, 0, 32'h11, 0, 0, 0);
      tick(); wb_valid = '0;
      tick();
      checks++; if (cm_valid !== 2'b00) begin errors++; $display("FAIL mc_wait_head got=%0b want=00", cm_valid); end
      drive_wb(3'b001, 0, 0, 0, 32'h10, 0, 0, 0);
      tick(); wb_valid = '0;
      checks++; if (cm_valid !== 2'b00) begin errors++; $display("FAIL mc_latency got=%0b want=00", cm_valid); end
      tick();
      checks++; if (cm_valid !== 2'b11) begin errors++; $display("FAIL mc_valid got=%0b want=11", cm_valid); end
      checks++; if (cm_id !== 8'h10) begin errors++; $display("FAIL mc_id got=%0h want=10", cm_id); end
      checks++; if (head_id !== 4'd2 || count !== 5'd2) begin errors++; $display("FAIL mc_head got head=%0d count=%0d want 2 2", head_id, count); end
      drive_wb(3'b110, 0, 3, 2, 0, 32'h13, 32'h12, 0);
      tick(); wb_valid = '0;
      tick();
      checks++; if (cm_valid !== 2'b11 || cm_id !== 8'h32) begin errors++; $display("FAIL mc_pair2 got v=%0b id=%0h want 11 32", cm_valid, cm_id); end
      checks++; if (head_id !== 4'd4 || count !== 5'd0) begin errors++; $display("FAIL mc_drain got head=%0d count=%0d want 4 0", head_id, count); end
   endtask

   task automatic test_full_and_wrap();
      bit ok;
      apply_reset();
      for (int i = 0; i < DEPTH; i++) do_issue(6'd0, REG_W'(i + 1), 32'(i * 4), 32'd0, 1'b0);
      checks++; if (count !== 5'd16 || issue_ready !== 1'b0) begin errors++; $display("FAIL full_state got count=%0d ready=%0b want 16 0", count, issue_ready); end
      issue_valid = 1'b1; tick(); issue_valid = 1'b0;
      checks++; if (count !== 5'd16 || issue_id !== 4'd0) begin errors++; $display("FAIL full_drop got count=%0d tail=%0d want 16 0", count, issue_id); end
      drive_wb(3'b001, 0, 0, 0, 32'hA0, 0, 0, 0);
      issue_valid = 1'b1;
      tick(); wb_valid = '0; issue_valid = 1'b0;
      checks++; if (count !== 5'd16 || cm_valid !== 2'b00) begin errors++; $display("FAIL full_wb_edge got count=%0d cm=%0b want 16 00", count, cm_valid); end
      tick();
      checks++; if (cm_valid !== 2'b01 || count !== 5'd15) begin errors++; $display("FAIL full_retire got cm=%0b count=%0d want 01 15", cm_valid, count); end
      checks++; if (issue_id !== 4'd0 || head_id !== 4'd1) begin errors++; $display("FAIL full_tail got tail=%0d head=%0d want 0 1", issue_id, head_id); end
      for (int b = 0; b < 5; b++) begin
         drive_wb((b == 4) ? 3'b011 : 3'b111, 1 + 3*b, 2 + 3*b, 3 + 3*b,
                  32'h100 + 32'(1 + 3*b), 32'h100 + 32'(2 + 3*b), 32'h100 + 32'(3 + 3*b), 0);
         tick(); wb_valid = '0;
      end
      ok = 1'b0;
      for (int c = 0; c < 40 && !ok; c++) begin
         if (head_id == 4'd15 && count == 5'd1) ok = 1'b1; else tick();
      end
      checks++; if (!ok) begin errors++; $display("FAIL wrap_reach got head=%0d count=%0d want 15 1", head_id, count); end
      for (int i = 0; i < 4; i++) do_issue(6'd0, REG_W'(20 + i), 32'h800, 32'd0, 1'b0);
      drive_wb(3'b111, 0, 15, 3, 32'h100, 32'h1515, 32'h333, 0);
      q1_id = 4'd3; q2_id = 4'd2;
      #1;
      checks++; if (q1_ready !== 1'b1 || q1_value !== 32'h333) begin errors++; $display("FAIL bypass_q1 got r=%0b v=%0h want 1 333", q1_ready, q1_value); end
      checks++; if (q2_ready !== 1'b0 || q2_value !== 32'd0) begin errors++; $display("FAIL bypass_q2 got r=%0b v=%0h want 0 0", q2_ready, q2_value); end
      tick(); wb_valid = '0;
      tick();
      checks++; if (cm_valid !== 2'b11 || cm_id !== 8'h0F) begin errors++; $display("FAIL wrap_pair got v=%0b id=%0h want 11 0f", cm_valid, cm_id); end
      checks++; if (head_id !== 4'd1 || count !== 5'd3) begin errors++; $display("FAIL wrap_head got head=%0d count=%0d want 1 3", head_id, count); end
      drive_wb(3'b011, 1, 2, 0, 32'h201, 32'h202, 0, 0);
      tick(); wb_valid = '0;
      ok = 1'b0;
      for (int c = 0; c < 10 && !ok; c++) begin
         if (count == 5'd0) ok = 1'b1; else tick();
      end
      @(negedge clk_in); #1;
      checks++; if (!ok || exp_q.size() != 0) begin errors++; $display("FAIL wrap_drain got count=%0d pending=%0d want 0 0", count, exp_q.size()); end
   endtask

   task automatic test_branch_flush();
      apply_reset();
      do_issue(6'd4, 0, 32'h100, 32'h40, 1'b0);
      do_issue(6'd0, 5, 32'h104, 0, 1'b0);
      do_issue(6'd0, 6, 32'h108, 0, 1'b0);
      drive_wb(3'b001, 0, 0, 0, 32'h1, 0, 0, 0);
      tick(); wb_valid = '0;
      issue_op = 6'd0; issue_rd = 5'd9; issue_valid = 1'b1;
      tick(); issue_valid = 1'b0;
      checks++; if (bp_valid !== 1'b1 || bp_taken !== 1'b1 || bp_pred !== 1'b0 || bp_pc !== 32'h100) begin errors++; $display("FAIL br_bp got v=%0b t=%0b p=%0b pc=%0h want 1 1 0 100", bp_valid, bp_taken, bp_pred, bp_pc); end
      checks++; if (flush !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 32'h140) begin errors++; $display("FAIL br_flush got f=%0b r=%0b pc=%0h want 1 1 140", flush, redirect_valid, redirect_pc); end
      checks++; if (count !== 5'd0 || issue_id !== 4'd0 || head_id !== 4'd0 || issue_ready !== 1'b0) begin errors++; $display("FAIL br_empty got count=%0d tail=%0d head=%0d rdy=%0b want 0 0 0 0", count, issue_id, head_id, issue_ready); end
      drive_wb(3'b001, 1, 0, 0, 32'h55, 0, 0, 0);
      tick(); wb_valid = '0;
      exp_q.delete(); m_tail = 0;
      checks++; if (flush !== 1'b0 || redirect_valid !== 1'b0 || bp_valid !== 1'b0) begin errors++; $display("FAIL br_pulse_len got f=%0b r=%0b b=%0b want 0 0 0", flush, redirect_valid, bp_valid); end
      tick();
      checks++; if (cm_valid !== 2'b00 || count !== 5'd0 || issue_ready !== 1'b1) begin errors++; $display("FAIL br_young_wb got cm=%0b count=%0d rdy=%0b want 00 0 1", cm_valid, count, issue_ready); end
      do_issue(6'd5, 0, 32'h200, 32'h10, 1'b1);
      drive_wb(3'b001, 0, 0, 0, 32'h1, 0, 0, 0);
      tick(); wb_valid = '0;
      tick();
      checks++; if (bp_valid !== 1'b1 || bp_pred !== 1'b1 || flush !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL br_correct got b=%0b p=%0b f=%0b r=%0b want 1 1 0 0", bp_valid, bp_pred, flush, redirect_valid); end
      do_issue(6'd3, 1, 32'h300, 0, 1'b0);
      do_issue(6'd0, 2, 32'h304, 0, 1'b0);
      drive_wb(3'b011, 1, 2, 0, 32'h304, 32'h77, 0, 32'h4000);
      tick(); wb_valid = '0;
      tick();
      checks++; if (cm_valid !== 2'b01 || redirect_valid !== 1'b1 || redirect_pc !== 32'h4000 || flush !== 1'b0) begin errors++; $display("FAIL jalr got cm=%0b r=%0b pc=%0h f=%0b want 01 1 4000 0", cm_valid, redirect_valid, redirect_pc, flush); end
      tick();
      checks++; if (cm_valid !== 2'b01 || redirect_valid !== 1'b0 || head_id !== 4'd3 || count !== 5'd0) begin errors++; $display("FAIL jalr_next got cm=%0b r=%0b head=%0d count=%0d want 01 0 3 0", cm_valid, redirect_valid, head_id, count); end
   endtask

   task automatic test_halt();
      apply_reset();
      do_issue(6'd39, 0, 32'h400, 0, 1'b0);
      do_issue(6'd0, 3, 32'h404, 0, 1'b0);
      drive_wb(3'b011, 0, 1, 0, 32'h0, 32'h99, 0, 0);
      tick(); wb_valid = '0;
      tick();
      checks++; if (cm_valid !== 2'b01 || halt !== 1'b1) begin errors++; $display("FAIL halt_exit got cm=%0b halt=%0b want 01 1", cm_valid, halt); end
      tick(); tick(); tick();
      checks++; if (cm_valid !== 2'b00 || halt !== 1'b1 || count !== 5'd1) begin errors++; $display("FAIL halt_sticky got cm=%0b halt=%0b count=%0d want 00 1 1", cm_valid, halt, count); end
      rst_in = 1'b0;
      #1;
      checks++; if (halt !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL halt_reset got halt=%0b count=%0d want 0 0", halt, count); end
      apply_reset();
   endtask

   task automatic test_rdy_freeze();
      apply_reset();
      rdy_in = 1'b0;
      issue_op = 6'd0; issue_rd = 5'd7; issue_valid = 1'b1;
      tick(); issue_valid = 1'b0;
      checks++; if (count !== 5'd0 || issue_id !== 4'd0) begin errors++; $display("FAIL rdy_issue got count=%0d tail=%0d want 0 0", count, issue_id); end
      rdy_in = 1'b1;
      do_issue(6'd0, 7, 32'h500, 0, 1'b0);
      drive_wb(3'b001, 0, 0, 0, 32'h7777, 0, 0, 0);
      tick(); wb_valid = '0;
      rdy_in = 1'b0;
      q1_id = 4'd0;
      tick(); tick();
      checks++; if (cm_valid !== 2'b00 || count !== 5'd1) begin errors++; $display("FAIL rdy_hold got cm=%0b count=%0d want 00 1", cm_valid, count); end
      checks++; if (q1_ready !== 1'b1 || q1_value !== 32'h7777) begin errors++; $display("FAIL rdy_query got r=%0b v=%0h want 1 7777", q1_ready, q1_value); end
      rdy_in = 1'b1;
      tick();
      checks++; if (cm_valid !== 2'b01 || count !== 5'd0) begin errors++; $display("FAIL rdy_resume got cm=%0b count=%0d want 01 0", cm_valid, count); end
   endtask

   initial begin
      test_reset();
      test_multi_commit();
      test_full_and_wrap();
      test_branch_flush();
      test_halt();
      test_rdy_freeze();
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
